// File: rtl/cordic_job_arbiter.sv
// Two-requester round-robin front end for a shared iterative CORDIC core:
// grants one command, pulses start, waits for done (or times out) and returns a tagged result.
module cordic_job_arbiter #(
  parameter int FIXED_WIDTH = 16,
  parameter int SHIFT_W     = 5,
  parameter int TIMEOUT     = 63,
  localparam int CMD_W      = 3 + SHIFT_W + 2 * FIXED_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*CMD_W-1:0]     req_cmd,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [FIXED_WIDTH-1:0] rsp_out1,
  output logic [FIXED_WIDTH-1:0] rsp_out2,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   cx_start,
  output logic [1:0]             cx_mode,
  output logic                   cx_is_rotating,
  output logic [SHIFT_W-1:0]     cx_shift,
  output logic [FIXED_WIDTH-1:0] cx_a,
  output logic [FIXED_WIDTH-1:0] cx_b,
  input  logic [FIXED_WIDTH-1:0] cx_out1,
  input  logic [FIXED_WIDTH-1:0] cx_out2,
  input  logic                   cx_done
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q;
  logic                   ptr_q;
  logic                   id_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [FIXED_WIDTH-1:0] rsp_out1_q;
  logic [FIXED_WIDTH-1:0] rsp_out2_q;
  logic                   busy_q;
  logic                   cx_start_q;
  logic [1:0]             cx_mode_q;
  logic                   cx_is_rotating_q;
  logic [SHIFT_W-1:0]     cx_shift_q;
  logic [FIXED_WIDTH-1:0] cx_a_q;
  logic [FIXED_WIDTH-1:0] cx_b_q;

  logic [1:0]             grant_d;
  logic [CMD_W-1:0]       cmd_d;

  // On contention the pointer names the requester that currently has priority.
  always_comb begin
    grant_d = 2'b00;
    case (req_valid)
      2'b01:   grant_d = 2'b01;
      2'b10:   grant_d = 2'b10;
      2'b11:   grant_d = ptr_q ? 2'b10 : 2'b01;
      default: grant_d = 2'b00;
    endcase
    cmd_d = grant_d[1] ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
  end

  assign req_ready = (state_q == IDLE) ? grant_d : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= 1'b0;
      id_q             <= 1'b0;
      cnt_q            <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_out1_q       <= '0;
      rsp_out2_q       <= '0;
      busy_q           <= 1'b0;
      cx_start_q       <= 1'b0;
      cx_mode_q        <= 2'b00;
      cx_is_rotating_q <= 1'b0;
      cx_shift_q       <= '0;
      cx_a_q           <= '0;
      cx_b_q           <= '0;
    end else begin
      cx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant_d) begin
            id_q             <= grant_d[1];
            cx_is_rotating_q <= cmd_d[CMD_W-1];
            cx_mode_q        <= cmd_d[CMD_W-2 -: 2];
            cx_shift_q       <= cmd_d[2*FIXED_WIDTH +: SHIFT_W];
            cx_a_q           <= cmd_d[FIXED_WIDTH +: FIXED_WIDTH];
            cx_b_q           <= cmd_d[0 +: FIXED_WIDTH];
            busy_q           <= 1'b1;
            // Mode 3 is not a core operation: answer with an error and never start the core.
            if (cmd_d[CMD_W-2 -: 2] == 2'b11) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_out1_q  <= '0;
              rsp_out2_q  <= '0;
              state_q     <= RESP;
            end else begin
              cx_start_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cx_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_out1_q  <= cx_out1;
            rsp_out2_q  <= cx_out2;
            state_q     <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_out1_q  <= '0;
            rsp_out2_q  <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= ~id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = id_q;
  assign rsp_out1       = rsp_out1_q;
  assign rsp_out2       = rsp_out2_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = busy_q;
  assign cx_start       = cx_start_q;
  assign cx_mode        = cx_mode_q;
  assign cx_is_rotating = cx_is_rotating_q;
  assign cx_shift       = cx_shift_q;
  assign cx_a           = cx_a_q;
  assign cx_b           = cx_b_q;
endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Bench for cordic_job_arbiter: directed jobs against a cycle-stamped job model,
// plus literal latency/value expectations for each scenario.
module tb_cordic_job_arbiter;
  localparam int FW = 16;
  localparam int SW = 5;
  localparam int TO = 63;
  localparam int CW = 3 + SW + 2 * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*CW-1:0] req_cmd = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [FW-1:0] rsp_out1, rsp_out2;
  logic          rsp_err, busy, cx_start;
  logic [1:0]    cx_mode;
  logic          cx_is_rotating;
  logic [SW-1:0] cx_shift;
  logic [FW-1:0] cx_a, cx_b;
  logic [FW-1:0] cx_out1, cx_out2;
  logic          cx_done;

  cordic_job_arbiter #(.FIXED_WIDTH(FW), .SHIFT_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out1(rsp_out1),
    .rsp_out2(rsp_out2), .rsp_err(rsp_err), .busy(busy), .cx_start(cx_start), .cx_mode(cx_mode),
    .cx_is_rotating(cx_is_rotating), .cx_shift(cx_shift), .cx_a(cx_a), .cx_b(cx_b),
    .cx_out1(cx_out1), .cx_out2(cx_out2), .cx_done(cx_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic rot, input logic [1:0] mode,
      input logic [SW-1:0] sh, input logic [FW-1:0] a, input logic [FW-1:0] b);
    return {rot, mode, sh, a, b};
  endfunction

  // Core stand-in: done fires core_delay cycles after the start cycle (0 = never).
  int          core_delay = 0;
  int          pending    = 0;
  logic [FW-1:0] core_o1 = '0, core_o2 = '0;
  logic        force_done = 1'b0;
  initial begin
    cx_done = 1'b0; cx_out1 = '0; cx_out2 = '0;
    forever begin
      @(posedge clk); #2;
      cx_done = force_done;
      if (rst) pending = 0;
      else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          cx_done = 1'b1; cx_out1 = core_o1; cx_out2 = core_o2;
        end
      end
      if (cx_start && core_delay > 0 && !rst) pending = core_delay;
    end
  end

  // Job model: a job accepted in cycle A starts the core in A+1, may see done in A+2..A+65,
  // and responds the cycle after done, after the 64th wait cycle, or at A+1 for mode 3.
  logic          m_active = 1'b0, m_bad = 1'b0, m_ptr = 1'b0, m_id = 1'b0, m_err = 1'b0;
  int            m_acc = 0, m_resp = -1;
  logic [FW-1:0] m_out1 = '0, m_out2 = '0;
  logic [CW-1:0] m_cfg = '0;

  int            acc_cnt = 0, rsp_cnt = 0, start_cnt = 0;
  int            acc_cyc_q[$], rsp_first_q[$], rsp_hs_q[$], start_cyc_q[$];
  logic          acc_id_q[$], rsp_id_q[$], rsp_err_q[$];
  logic [FW-1:0] rsp_o1_q[$], rsp_o2_q[$], start_a_q[$];
  logic [SW-1:0] start_sh_q[$];

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    logic       e_rv, e_st;
    cyc++;
    if (rst) begin
      m_active = 1'b0; m_ptr = 1'b0; m_cfg = '0; m_id = 1'b0;
      m_err = 1'b0; m_out1 = '0; m_out2 = '0; m_resp = -1;
    end else begin
      e_rdy = 2'b00;
      if (!m_active) begin
        if (req_valid == 2'b11) e_rdy = m_ptr ? 2'b10 : 2'b01;
        else e_rdy = req_valid;
      end
      e_rv = m_active && (m_resp >= 0) && (cyc >= m_resp);
      e_st = m_active && !m_bad && (cyc == m_acc + 1);
      check("req_ready", 64'(req_ready), 64'(e_rdy));
      check("busy", 64'(busy), 64'(m_active));
      check("cx_start", 64'(cx_start), 64'(e_st));
      check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      check("cx_cfg", 64'({cx_is_rotating, cx_mode, cx_shift, cx_a, cx_b}), 64'(m_cfg));
      if (e_rv)
        check("rsp_data", 64'({rsp_id, rsp_err, rsp_out1, rsp_out2}), 64'({m_id, m_err, m_out1, m_out2}));
      if (cx_start) begin
        start_cnt++; start_cyc_q.push_back(cyc); start_a_q.push_back(cx_a); start_sh_q.push_back(cx_shift);
      end
      if (m_active && !m_bad && m_resp < 0) begin
        if (cyc >= m_acc + 2 && cx_done) begin
          m_resp = cyc + 1; m_out1 = cx_out1; m_out2 = cx_out2; m_err = 1'b0;
          rsp_first_q.push_back(m_resp);
        end else if (cyc == m_acc + 2 + TO) begin
          m_resp = cyc + 1; m_out1 = '0; m_out2 = '0; m_err = 1'b1;
          rsp_first_q.push_back(m_resp);
        end
      end
      if (e_rv && rsp_ready) begin
        $display("rsp cycle %0d id=%0d err=%0d out1=%04h out2=%04h", cyc, rsp_id, rsp_err, rsp_out1, rsp_out2);
        rsp_cnt++; rsp_hs_q.push_back(cyc); rsp_id_q.push_back(rsp_id); rsp_err_q.push_back(rsp_err);
        rsp_o1_q.push_back(rsp_out1); rsp_o2_q.push_back(rsp_out2);
        m_active = 1'b0; m_ptr = ~m_id;
      end else if (!m_active && e_rdy != 2'b00) begin
        m_active = 1'b1; m_acc = cyc; m_id = e_rdy[1];
        m_cfg = e_rdy[1] ? req_cmd[2*CW-1:CW] : req_cmd[CW-1:0];
        m_bad = (m_cfg[CW-2 -: 2] == 2'b11);
        m_resp = -1;
        if (m_bad) begin
          m_resp = cyc + 1; m_out1 = '0; m_out2 = '0; m_err = 1'b1;
          rsp_first_q.push_back(m_resp);
        end
        acc_cnt++; acc_cyc_q.push_back(cyc); acc_id_q.push_back(m_id);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int target);
    int i = 0;
    while (acc_cnt < target && i < 400) begin tick(); i++; end
    check("wait_accept", 64'(acc_cnt >= target), 64'(1));
  endtask

  task automatic wait_rsp(input int target);
    int i = 0;
    while (rsp_cnt < target && i < 400) begin tick(); i++; end
    check("wait_response", 64'(rsp_cnt >= target), 64'(1));
  endtask

  task automatic check_zero_outs();
    check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_out1, rsp_out2, busy}), 64'(0));
    check("rst_cx", 64'({cx_start, cx_is_rotating, cx_mode, cx_shift, cx_a, cx_b}), 64'(0));
  endtask

  // Runs one job from a single requester and checks the literal response latency and values.
  task automatic one_job(input logic who, input logic [CW-1:0] cmd, input int delay,
      input logic [FW-1:0] o1, input logic [FW-1:0] o2, input int exp_lat,
      input logic exp_err, input logic [FW-1:0] e1, input logic [FW-1:0] e2);
    int a0, r0;
    a0 = acc_cnt; r0 = rsp_cnt;
    core_delay = delay; core_o1 = o1; core_o2 = o2;
    if (who) req_cmd[2*CW-1:CW] = cmd; else req_cmd[CW-1:0] = cmd;
    req_valid = who ? 2'b10 : 2'b01;
    wait_acc(a0 + 1);
    req_valid = 2'b00;
    wait_rsp(r0 + 1);
    check("job_latency", 64'(rsp_first_q[$] - acc_cyc_q[$]), 64'(exp_lat));
    check("job_id", 64'(rsp_id_q[$]), 64'(who));
    check("job_err", 64'(rsp_err_q[$]), 64'(exp_err));
    check("job_outs", 64'({rsp_o1_q[$], rsp_o2_q[$]}), 64'({e1, e2}));
  endtask

  int s0, a0, r0, r_first;

  initial begin
    #2 rst = 1'b1;
    #1 check_zero_outs();
    tick(); tick(); rst = 1'b0;

    // Both requesters valid from reset: strict alternation starting at requester 0.
    req_cmd[CW-1:0]    = mk_cmd(1'b0, 2'd1, 5'd3, 16'h0100, 16'h0200);
    req_cmd[2*CW-1:CW] = mk_cmd(1'b1, 2'd2, 5'd4, 16'h0300, 16'h0400);
    core_delay = 3; core_o1 = 16'hAAAA; core_o2 = 16'h5555;
    req_valid = 2'b11;
    wait_rsp(4);
    req_valid = 2'b00;
    check("rr_order", 64'({acc_id_q[0], acc_id_q[1], acc_id_q[2], acc_id_q[3]}), 64'(4'b0101));
    check("rr_rsp_ids", 64'({rsp_id_q[0], rsp_id_q[1], rsp_id_q[2], rsp_id_q[3]}), 64'(4'b0101));

    // Single job from requester 0, done 14 cycles after start.
    s0 = start_cnt;
    one_job(1'b0, mk_cmd(1'b1, 2'd0, 5'd11, 16'h0400, 16'h0000), 14, 16'h1234, 16'h5678,
            16, 1'b0, 16'h1234, 16'h5678);
    check("start_count", 64'(start_cnt - s0), 64'(1));
    check("start_cycle", 64'(start_cyc_q[$] - acc_cyc_q[$]), 64'(1));
    check("start_cfg", 64'({start_a_q[$], start_sh_q[$]}), 64'({16'h0400, 5'd11}));

    // Mode 3 from requester 1: immediate error, core never started.
    s0 = start_cnt;
    one_job(1'b1, mk_cmd(1'b0, 2'd3, 5'd0, 16'h1111, 16'h2222), 5, 16'hDEAD, 16'hDEAD,
            1, 1'b1, 16'h0000, 16'h0000);
    check("bad_mode_no_start", 64'(start_cnt), 64'(s0));

    // Core never answers: error after 64 wait cycles, then a normal job.
    one_job(1'b0, mk_cmd(1'b0, 2'd1, 5'd2, 16'h0042, 16'h0043), 0, 16'hDEAD, 16'hDEAD,
            66, 1'b1, 16'h0000, 16'h0000);
    one_job(1'b1, mk_cmd(1'b1, 2'd0, 5'd7, 16'h0011, 16'h0022), 5, 16'hBEEF, 16'h0042,
            7, 1'b0, 16'hBEEF, 16'h0042);

    // Done on the very cycle the timeout would fire: done wins.
    one_job(1'b0, mk_cmd(1'b1, 2'd2, 5'd9, 16'h0055, 16'h0066), 64, 16'h7777, 16'h8888,
            66, 1'b0, 16'h7777, 16'h8888);

    // Backpressure: response held 5 cycles with both requesters waiting.
    a0 = acc_cnt; r0 = rsp_cnt;
    req_cmd[CW-1:0]    = mk_cmd(1'b0, 2'd1, 5'd1, 16'h0A0A, 16'h0B0B);
    req_cmd[2*CW-1:CW] = mk_cmd(1'b1, 2'd1, 5'd2, 16'h0C0C, 16'h0D0D);
    core_delay = 4; core_o1 = 16'h1357; core_o2 = 16'h2468;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    s0 = rsp_first_q.size();
    for (int i = 0; i < 400 && rsp_first_q.size() == s0; i++) tick();
    check("bp_rsp_seen", 64'(rsp_first_q.size()), 64'(s0 + 1));
    r_first = rsp_first_q[$];
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_acc(a0 + 2);
    req_valid = 2'b00;
    wait_rsp(r0 + 2);
    check("bp_handshake_cycle", 64'(rsp_hs_q[r0] - r_first), 64'(5));
    check("bp_grant_order", 64'({acc_id_q[a0], acc_id_q[a0 + 1]}), 64'(2'b10));

    // Reset during WAIT, then a stray done; first job afterwards from requester 1.
    a0 = acc_cnt; r0 = rsp_cnt;
    core_delay = 0;
    req_cmd[CW-1:0] = mk_cmd(1'b1, 2'd0, 5'd5, 16'h0F0F, 16'h0E0E);
    req_valid = 2'b01;
    wait_acc(a0 + 1);
    req_valid = 2'b00;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 check_zero_outs();
    tick(); rst = 1'b0;
    force_done = 1'b1;
    tick(); force_done = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", 64'({rsp_valid, busy}), 64'(0));
    check("post_rst_no_rsp", 64'(rsp_cnt), 64'(r0));
    one_job(1'b1, mk_cmd(1'b0, 2'd2, 5'd6, 16'h0123, 16'h0456), 6, 16'h0101, 16'h0202,
            8, 1'b0, 16'h0101, 16'h0202);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
